mem_fill_responder: RTL and testbench

Main-memory side of the cache fill protocol. Accepts block-fill requests from the instruction and data cache interfaces, arbitrates between them, and reads a 16-byte block (eight 16-bit words) from the fixed-latency backing memory. It streams the words back one per cycle with their addresses and a per-requester cache write enable. It drives the shared memory-stall signal that both cache interfaces consume.

---
 rtl/mem_fill_pkg.sv | 24 ++
 rtl/fill_latency_pipe.sv | 51 +++++
 rtl/mem_fill_responder.sv | 124 ++++++++++++
 tb/tb_mem_fill_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg
//   Shared types and constants for the cache-fill responder.
//   - fill_state_e : responder FSM states
//   - owner_e      : which cache interface owns the current fill
//   - BLOCK_BYTES / WORD_BYTES / BLOCK_MASK : block geometry (16-byte blocks of 16-bit words)
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  localparam int          BLOCK_BYTES = 16;
  localparam int          WORD_BYTES  = 2;
  localparam logic [15:0] BLOCK_MASK  = ~16'(BLOCK_BYTES - 1);

endpackage

// File: rtl/fill_latency_pipe.sv
// fill_latency_pipe
//   DEPTH-deep shift register of {valid, addr} that tracks backing-memory reads
//   in flight. An entry enters at stage 0 on the cycle the read is issued and
//   reaches the head exactly DEPTH cycles later, aligned with the read data.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low clear of every stage
//   in_valid   in   a read is being issued this cycle
//   in_addr    in   byte address of that read
//   head_valid out  oldest stage holds a read whose data is on the bus now
//   head_addr  out  byte address belonging to that data
module fill_latency_pipe #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          head_valid,
  output logic [AW-1:0] head_addr
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];

  always_comb begin
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= addr_d[i];
    end
  end

  assign head_valid = valid_q[DEPTH-1];
  assign head_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder
//   Memory side of the cache fill protocol. Arbitrates D/I fill requests
//   (data cache wins ties), issues one backing-memory read per cycle for the
//   whole block, then streams the returned words to the owning cache.
// Ports:
//   clk, rst                          clock; asynchronous active-low reset
//   DMemoryRequest/DMemoryAddress     data-cache fill request and miss address
//   IMemoryRequest/IMemoryAddress     instruction-cache fill request and miss address
//   MemRdEn/MemRdAddr                 backing-memory read strobe and byte address
//   MemRdData                         backing read data, MEM_LATENCY cycles after MemRdEn
//   MemData/MemAddress                fill word and its byte address
//   DCacheWriteEnable/ICacheWriteEnable  fill word belongs to D / I cache
//   MemStall                          responder busy
module mem_fill_responder
  import mem_fill_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMemoryRequest,
  input  logic [15:0] DMemoryAddress,
  input  logic        IMemoryRequest,
  input  logic [15:0] IMemoryAddress,
  output logic        MemRdEn,
  output logic [15:0] MemRdAddr,
  input  logic [15:0] MemRdData,
  output logic [15:0] MemData,
  output logic [15:0] MemAddress,
  output logic        DCacheWriteEnable,
  output logic        ICacheWriteEnable,
  output logic        MemStall
);

  localparam int               CNT_W    = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_e      state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  logic             issuing;
  logic [15:0]      issue_addr;
  logic             head_valid;
  logic [15:0]      head_addr;

  assign issuing    = (state_q == ISSUE);
  assign issue_addr = base_q + 16'(issue_cnt_q) * 16'(WORD_BYTES);

  fill_latency_pipe #(
    .DEPTH (MEM_LATENCY),
    .AW    (16)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst),
    .in_valid   (issuing),
    .in_addr    (issue_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    // Returns are counted wherever they land; they only ever occur during a fill.
    ret_cnt_d   = head_valid ? ret_cnt_q + CNT_W'(1) : ret_cnt_q;

    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (DMemoryRequest) begin
          state_d = ISSUE;
          owner_d = OWN_D;
          base_d  = DMemoryAddress & BLOCK_MASK;
        end else if (IMemoryRequest) begin
          state_d = ISSUE;
          owner_d = OWN_I;
          base_d  = IMemoryAddress & BLOCK_MASK;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        // The last return of the block is being presented this cycle.
        if (head_valid && ret_cnt_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign MemStall          = (state_q != IDLE);
  assign MemRdEn           = issuing;
  assign MemRdAddr         = issuing ? issue_addr : 16'h0000;
  assign MemData           = head_valid ? MemRdData : 16'h0000;
  assign MemAddress        = head_valid ? head_addr : 16'h0000;
  assign DCacheWriteEnable = head_valid && (owner_q == OWN_D);
  assign ICacheWriteEnable = head_valid && (owner_q == OWN_I);

endmodule

// File: tb/tb_mem_fill_responder.sv
module tb_mem_fill_responder;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        DMemoryRequest, IMemoryRequest;
  logic [15:0] DMemoryAddress, IMemoryAddress;
  logic        MemRdEn;
  logic [15:0] MemRdAddr;
  logic [15:0] MemRdData;
  logic [15:0] MemData, MemAddress;
  logic        DCacheWriteEnable, ICacheWriteEnable, MemStall;

  mem_fill_responder #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(L)) dut (
    .clk               (clk),
    .rst               (rst),
    .DMemoryRequest    (DMemoryRequest),
    .DMemoryAddress    (DMemoryAddress),
    .IMemoryRequest    (IMemoryRequest),
    .IMemoryAddress    (IMemoryAddress),
    .MemRdEn           (MemRdEn),
    .MemRdAddr         (MemRdAddr),
    .MemRdData         (MemRdData),
    .MemData           (MemData),
    .MemAddress        (MemAddress),
    .DCacheWriteEnable (DCacheWriteEnable),
    .ICacheWriteEnable (ICacheWriteEnable),
    .MemStall          (MemStall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] mem_seed = 16'h5A5A;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd40503) ^ mem_seed;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Backing memory: data for a read issued in cycle k is presented in cycle k+L.
  typedef struct packed { logic en; logic [15:0] addr; } rd_t;
  rd_t hist [L+1];
  initial begin
    for (int i = 0; i <= L; i++) hist[i] = '0;
    MemRdData = 16'hDEAD;
  end
  always @(posedge clk) begin
    #1;
    for (int i = L; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {MemRdEn, MemRdAddr};
    MemRdData = hist[L].en ? mem_word(hist[L].addr) : 16'hDEAD;
  end

  // Write log and read-burst start log
  typedef struct { logic own; logic [15:0] addr; int c; } wr_t;
  wr_t wq[$];
  int  rd_start[$];
  logic prev_en = 1'b0;

  // Reference model: a fill is a timeline relative to the cycle t0 in which
  // the request was sampled; everything else is plain arithmetic on k=cyc-t0.
  logic        m_busy = 1'b0;
  int          m_t0   = 0;
  logic        m_own  = 1'b0;
  logic [15:0] m_base = 16'h0;

  always @(negedge clk) begin
    logic        e_stall, e_rden, e_dwe, e_iwe;
    logic [15:0] e_rdaddr, e_data, e_addr;
    int          k;
    e_stall = 0; e_rden = 0; e_dwe = 0; e_iwe = 0;
    e_rdaddr = 0; e_data = 0; e_addr = 0;
    if (!rst) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy && (cyc - m_t0) == 10 + L) m_busy = 1'b0;
      if (m_busy) begin
        k = cyc - m_t0;
        e_stall = (k >= 1 && k <= 9 + L);
        if (k >= 1 && k <= 8) begin
          e_rden   = 1'b1;
          e_rdaddr = m_base + 16'(2 * (k - 1));
        end
        if (k >= 1 + L && k <= 8 + L) begin
          e_addr = m_base + 16'(2 * (k - 1 - L));
          e_data = mem_word(e_addr);
          if (m_own) e_iwe = 1'b1; else e_dwe = 1'b1;
        end
      end
    end
    check("outputs",
          {MemStall, MemRdEn, MemRdAddr, MemData, MemAddress, DCacheWriteEnable, ICacheWriteEnable},
          {e_stall, e_rden, e_rdaddr, e_data, e_addr, e_dwe, e_iwe});
    check("we_exclusive", 64'(DCacheWriteEnable & ICacheWriteEnable), 64'(0));
    if (DCacheWriteEnable || ICacheWriteEnable)
      wq.push_back('{own: ICacheWriteEnable, addr: MemAddress, c: cyc});
    if (MemRdEn && !prev_en) rd_start.push_back(cyc);
    prev_en = MemRdEn;
    if (rst && !m_busy) begin
      if (DMemoryRequest) begin
        m_busy = 1'b1; m_t0 = cyc; m_own = 1'b0; m_base = DMemoryAddress & 16'hFFF0;
      end else if (IMemoryRequest) begin
        m_busy = 1'b1; m_t0 = cyc; m_own = 1'b1; m_base = IMemoryAddress & 16'hFFF0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_stall(input logic lvl);
    int n;
    n = 0;
    while (MemStall !== lvl && n < 60) begin
      tick();
      n++;
    end
    check("stall_wait", 64'(MemStall), 64'(lvl));
  endtask

  typedef struct {
    logic d; logic [15:0] da; logic i; logic [15:0] ia;
    logic own1; logic [15:0] base1;
    logic two; logic own2; logic [15:0] base2;
  } vec_t;

  task automatic run_vec(input vec_t v);
    wq.delete();
    DMemoryRequest = v.d; DMemoryAddress = v.da;
    IMemoryRequest = v.i; IMemoryAddress = v.ia;
    tick();
    wait_stall(1'b1);
    if (v.own1) IMemoryRequest = 1'b0; else DMemoryRequest = 1'b0;
    if (v.two) begin
      wait_stall(1'b0);
      wait_stall(1'b1);
      if (v.own2) IMemoryRequest = 1'b0; else DMemoryRequest = 1'b0;
    end
    wait_stall(1'b0);
    repeat (3) tick();
    check("vec_nwrites", 64'(wq.size()), v.two ? 64'(16) : 64'(8));
    if (wq.size() >= 8) begin
      check("vec_first_own",  64'(wq[0].own),  64'(v.own1));
      check("vec_first_addr", 64'(wq[0].addr), 64'(v.base1));
      check("vec_last_addr",  64'(wq[7].addr), 64'(v.base1 + 16'd14));
    end
    if (v.two && wq.size() >= 16) begin
      check("vec_second_own",  64'(wq[8].own),  64'(v.own2));
      check("vec_second_addr", 64'(wq[8].addr), 64'(v.base2));
      check("vec_second_gap",  64'(wq[8].c - wq[0].c), 64'(10 + L));
    end
  endtask

  vec_t vecs[6];

  initial begin
    int t0, n;
    logic [15:0] first_i_addr;
    int          first_i_cyc;

    vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h1230, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 16'h0040, 1'b1, 16'h2008, 1'b0, 16'h0040, 1'b1, 1'b1, 16'h2000};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h2008, 1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 16'hFFF6, 1'b0, 16'h0000, 1'b0, 16'hFFF0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 16'h8001, 1'b1, 16'h777F, 1'b0, 16'h8000, 1'b1, 1'b1, 16'h7770};

    mem_seed = 16'($urandom);
    rst = 1'b0;
    DMemoryRequest = 1'b0; DMemoryAddress = 16'h0;
    IMemoryRequest = 1'b0; IMemoryAddress = 16'h0;
    #1;
    check("reset_state",
          {MemStall, MemRdEn, MemRdAddr, MemData, MemAddress, DCacheWriteEnable, ICacheWriteEnable},
          52'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // I request raised in cycle 3 of a D fill waits for IDLE.
    wq.delete();
    DMemoryRequest = 1'b1; DMemoryAddress = 16'h0300;
    tick();
    wait_stall(1'b1);
    t0 = cyc - 1;
    DMemoryRequest = 1'b0;
    while (cyc < t0 + 3) tick();
    IMemoryRequest = 1'b1; IMemoryAddress = 16'h2468;
    first_i_cyc = -1; first_i_addr = 16'h0; n = 0;
    while (first_i_cyc < 0 && n < 40) begin
      tick();
      n++;
      foreach (wq[j]) if (wq[j].own && first_i_cyc < 0) begin
        first_i_cyc = wq[j].c; first_i_addr = wq[j].addr;
      end
    end
    IMemoryRequest = 1'b0;
    check("late_i_first_cycle", 64'(first_i_cyc - t0), 64'(19));
    check("late_i_first_addr",  64'(first_i_addr), 64'(16'h2460));
    wait_stall(1'b0);
    repeat (3) tick();

    // Reset in cycle 7 of a fill.
    DMemoryRequest = 1'b1; DMemoryAddress = 16'h0500;
    tick();
    wait_stall(1'b1);
    t0 = cyc - 1;
    DMemoryRequest = 1'b0;
    while (cyc < t0 + 7) tick();
    rst = 1'b0;
    #1;
    check("rst_immediate",
          {MemStall, MemRdEn, MemRdAddr, MemData, MemAddress, DCacheWriteEnable, ICacheWriteEnable},
          52'd0);
    repeat (2) tick();
    rst = 1'b1;
    wq.delete();
    repeat (20) tick();
    check("no_we_after_rst", 64'(wq.size()), 64'(0));
    run_vec('{1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000});

    // D held through DONE is served again as a fresh fill.
    wq.delete(); rd_start.delete();
    DMemoryRequest = 1'b1; DMemoryAddress = 16'h0A0C;
    n = 0;
    while (rd_start.size() < 2 && n < 60) begin
      tick();
      n++;
    end
    DMemoryRequest = 1'b0;
    check("held_two_bursts", 64'(rd_start.size()), 64'(2));
    if (rd_start.size() >= 2)
      check("held_restart_gap", 64'(rd_start[1] - rd_start[0]), 64'(10 + L));
    wait_stall(1'b0);
    repeat (3) tick();
    check("held_nwrites", 64'(wq.size()), 64'(16));
    if (wq.size() >= 16) begin
      check("held_addr_a", 64'(wq[0].addr), 64'(16'h0A00));
      check("held_addr_b", 64'(wq[8].addr), 64'(16'h0A00));
    end

    // Randomized traffic; the per-cycle model does the checking.
    for (int it = 0; it < 40; it++) begin
      DMemoryRequest = 1'($urandom);
      IMemoryRequest = 1'($urandom);
      DMemoryAddress = 16'($urandom);
      IMemoryAddress = 16'($urandom);
      n = $urandom_range(1, 30);
      for (int c = 0; c < n; c++) begin
        tick();
        if ($urandom_range(0, 63) == 0) begin
          rst = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
          rst = 1'b1;
        end
      end
      DMemoryRequest = 1'b0;
      IMemoryRequest = 1'b0;
      repeat ($urandom_range(0, 20)) tick();
    end
    rst = 1'b1;
    wait_stall(1'b0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
